// File: rtl/pipe_stage_chain.sv
// Chain of valid/ready pipeline registers with bubble collapse, per-stage flush,
// global stall, occupancy and a saturating kill counter.
module pipe_stage_chain #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 3,
    parameter int unsigned KCW    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         stall,
    input  logic [STAGES-1:0]            flush,
    output logic [STAGES-1:0]            stage_valid,
    output logic [STAGES*WIDTH-1:0]      stage_data,
    output logic [$clog2(STAGES+1)-1:0]  occupancy,
    output logic [KCW-1:0]               kill_cnt
);

    localparam int unsigned OCW = $clog2(STAGES + 1);
    localparam int unsigned SW  = KCW + OCW;
    localparam logic [SW-1:0] KillMax = SW'({KCW{1'b1}});

    logic [STAGES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [OCW-1:0]    occ_q, occ_d;
    logic [KCW-1:0]    kill_q, kill_d;

    logic [STAGES-1:0] ev;
    logic [STAGES-1:0] mv;
    logic              mv_in;
    logic              path_free;
    logic [OCW-1:0]    kills;
    logic [SW-1:0]     kill_sum;

    // Walk from the output back to the input: a stage may move when the
    // stage ahead of it is empty (after flush) or is itself moving.
    always_comb begin
        ev        = valid_q & ~flush;
        mv        = '0;
        path_free = out_ready & ~stall;
        for (int i = STAGES - 1; i >= 0; i--) begin
            mv[i]     = ev[i] & path_free;
            path_free = ~stall & (~ev[i] | mv[i]);
        end
        mv_in = in_valid & path_free;
    end

    assign in_ready  = ~stall & (~ev[0] | mv[0]);
    assign out_valid = ev[STAGES-1] & ~stall;
    assign out_data  = data_q[STAGES-1];

    always_comb begin
        valid_d = '0;
        data_d  = data_q;
        if (mv_in) begin
            valid_d[0] = 1'b1;
            data_d[0]  = in_data;
        end else begin
            valid_d[0] = ev[0] & ~mv[0];
        end
        for (int i = 1; i < STAGES; i++) begin
            if (mv[i-1]) begin
                valid_d[i] = 1'b1;
                data_d[i]  = data_q[i-1];
            end else begin
                valid_d[i] = ev[i] & ~mv[i];
            end
        end
    end

    always_comb begin
        occ_d = '0;
        kills = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + OCW'(valid_d[i]);
            kills = kills + OCW'(valid_q[i] & flush[i]);
        end
        kill_sum = SW'(kill_q) + SW'(kills);
        kill_d   = (kill_sum > KillMax) ? {KCW{1'b1}} : kill_sum[KCW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            kill_q  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            kill_q  <= kill_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_flat
        assign stage_data[g*WIDTH +: WIDTH] = data_q[g];
    end

    assign stage_valid = valid_q;
    assign occupancy   = occ_q;
    assign kill_cnt    = kill_q;

endmodule
